// File: rtl/cpu_pkg.sv
// Shared definitions for the multicycle controller: FSM states, instruction
// field codes, ALU operation codes and datapath mux selects.
package cpu_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JEX     = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_ONE   = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

endpackage

// File: rtl/aludec.sv
// ALU decoder: maps the controller's aluop class and the R-type funct field
// to the 3-bit alucontrol, flagging funct codes the ALU does not implement.
module aludec
  import cpu_pkg::*;
#(
  parameter int FNW = 6
) (
  input  logic [1:0]     aluop,
  input  logic [FNW-1:0] funct,
  output logic [2:0]     alucontrol,
  output logic           illegal
);

  always_comb begin
    alucontrol = ALU_ADD;
    illegal    = 1'b0;
    case (aluop)
      ALUOP_SUB: alucontrol = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FNW'(FN_ADD): alucontrol = ALU_ADD;
          FNW'(FN_SUB): alucontrol = ALU_SUB;
          FNW'(FN_AND): alucontrol = ALU_AND;
          FNW'(FN_OR):  alucontrol = ALU_OR;
          FNW'(FN_SLT): alucontrol = ALU_SLT;
          default:      illegal    = 1'b1;
        endcase
      end
      default: alucontrol = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multicycle main controller: Moore FSM over fetch/decode/execute/memory/
// writeback with memory-ready stalls, driving datapath enables and selects.
module mc_controller
  import cpu_pkg::*;
#(
  parameter int OPW = 6,
  parameter int FNW = 6
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic [OPW-1:0] op,
  input  logic [FNW-1:0] funct,
  input  logic           zero,
  input  logic           mem_ready,
  output logic           pcen,
  output logic           iord,
  output logic           memread,
  output logic           memwrite,
  output logic           irwrite,
  output logic           regdst,
  output logic           memtoreg,
  output logic           regwrite,
  output logic           alusrca,
  output logic [1:0]     alusrcb,
  output logic [1:0]     pcsrc,
  output logic [2:0]     alucontrol,
  output logic           illegal_op
);

  state_t     r_state;
  logic       r_is_lw;

  logic       w_op_legal;
  logic [1:0] w_aluop;
  logic       w_funct_illegal;
  logic       w_pcwrite;
  logic       w_branch;
  logic       w_memread;
  logic       w_memwrite;
  logic       w_irwrite;
  logic       w_regwrite;
  logic       w_illegal;

  always_comb begin
    case (op)
      OPW'(OP_RTYPE), OPW'(OP_LW), OPW'(OP_SW),
      OPW'(OP_BEQ), OPW'(OP_ADDI), OPW'(OP_J): w_op_legal = 1'b1;
      default:                                 w_op_legal = 1'b0;
    endcase
  end

  aludec #(.FNW(FNW)) u_aludec (
    .aluop      (w_aluop),
    .funct      (funct),
    .alucontrol (alucontrol),
    .illegal    (w_funct_illegal)
  );

  // The LW/SW choice is captured in DECODE so op is not needed in MEMADR.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_FETCH;
      r_is_lw <= 1'b0;
    end else begin
      case (r_state)
        S_FETCH: if (mem_ready) r_state <= S_DECODE;
        S_DECODE: begin
          r_is_lw <= (op == OPW'(OP_LW));
          case (op)
            OPW'(OP_LW), OPW'(OP_SW): r_state <= S_MEMADR;
            OPW'(OP_RTYPE):           r_state <= S_RTYPEEX;
            OPW'(OP_BEQ):             r_state <= S_BEQEX;
            OPW'(OP_ADDI):            r_state <= S_ADDIEX;
            OPW'(OP_J):               r_state <= S_JEX;
            default:                  r_state <= S_FETCH;
          endcase
        end
        S_MEMADR:  r_state <= r_is_lw ? S_MEMRD : S_MEMWR;
        S_MEMRD:   if (mem_ready) r_state <= S_MEMWB;
        S_MEMWR:   if (mem_ready) r_state <= S_FETCH;
        S_RTYPEEX: r_state <= w_funct_illegal ? S_FETCH : S_RTYPEWB;
        S_ADDIEX:  r_state <= S_ADDIWB;
        default:   r_state <= S_FETCH;
      endcase
    end
  end

  always_comb begin
    w_pcwrite  = 1'b0;
    w_branch   = 1'b0;
    w_memread  = 1'b0;
    w_memwrite = 1'b0;
    w_irwrite  = 1'b0;
    w_regwrite = 1'b0;
    w_illegal  = 1'b0;
    iord       = 1'b0;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = SRCB_REG;
    pcsrc      = PC_ALU;
    w_aluop    = ALUOP_ADD;
    case (r_state)
      S_FETCH: begin
        w_memread = 1'b1;
        alusrcb   = SRCB_ONE;
        w_irwrite = mem_ready;
        w_pcwrite = mem_ready;
      end
      S_DECODE: begin
        alusrcb   = SRCB_IMMSH;
        w_illegal = ~w_op_legal;
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = SRCB_IMM;
      end
      S_MEMRD: begin
        w_memread = 1'b1;
        iord      = 1'b1;
      end
      S_MEMWB: begin
        w_regwrite = 1'b1;
        memtoreg   = 1'b1;
      end
      S_MEMWR: begin
        w_memwrite = 1'b1;
        iord       = 1'b1;
      end
      S_RTYPEEX: begin
        alusrca   = 1'b1;
        w_aluop   = ALUOP_FUNCT;
        w_illegal = w_funct_illegal;
      end
      S_RTYPEWB: begin
        w_regwrite = 1'b1;
        regdst     = 1'b1;
      end
      S_BEQEX: begin
        alusrca  = 1'b1;
        w_aluop  = ALUOP_SUB;
        w_branch = 1'b1;
        pcsrc    = PC_ALUOUT;
      end
      S_ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = SRCB_IMM;
      end
      S_ADDIWB: w_regwrite = 1'b1;
      S_JEX: begin
        w_pcwrite = 1'b1;
        pcsrc     = PC_JUMP;
      end
      default: begin
        w_memread = 1'b1;
        alusrcb   = SRCB_ONE;
      end
    endcase
  end

  // Strobes are gated by reset_n so nothing fires while reset is held.
  assign pcen       = reset_n & (w_pcwrite | (w_branch & zero));
  assign memread    = reset_n & w_memread;
  assign memwrite   = reset_n & w_memwrite;
  assign irwrite    = reset_n & w_irwrite;
  assign regwrite   = reset_n & w_regwrite;
  assign illegal_op = reset_n & w_illegal;

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller: expected output vectors are queued as
// each cycle is driven and popped against the DUT outputs mid-cycle.
module tb_mc_controller;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic       pcen, iord, memread, memwrite, irwrite, regdst, memtoreg;
  logic       regwrite, alusrca, illegal_op;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;

  mc_controller #(.OPW(6), .FNW(6)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .op         (op),
    .funct      (funct),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .pcen       (pcen),
    .iord       (iord),
    .memread    (memread),
    .memwrite   (memwrite),
    .irwrite    (irwrite),
    .regdst     (regdst),
    .memtoreg   (memtoreg),
    .regwrite   (regwrite),
    .alusrca    (alusrca),
    .alusrcb    (alusrcb),
    .pcsrc      (pcsrc),
    .alucontrol (alucontrol),
    .illegal_op (illegal_op)
  );

  always #5 clk = ~clk;

  typedef enum int {
    T_RESET, T_FETCH, T_DECODE, T_MEMADR, T_MEMRD, T_MEMWB, T_MEMWR,
    T_RTYPEEX, T_RTYPEWB, T_BEQEX, T_ADDIEX, T_ADDIWB, T_JEX
  } tb_st_e;

  logic [16:0] obs;
  assign obs = {pcen, iord, memread, memwrite, irwrite, regdst, memtoreg,
                regwrite, alusrca, alusrcb, pcsrc, alucontrol, illegal_op};

  logic [16:0] sb_q[$];
  string       tag_q[$];
  int          n_vec = 0;
  int          n_err = 0;

  function automatic logic [16:0] exp_vec(input tb_st_e st, input logic mr,
                                          input logic z, input logic [5:0] o,
                                          input logic [5:0] f);
    logic e_pcen, e_iord, e_mrd, e_mwr, e_ir, e_rd, e_m2r, e_rw, e_sa, e_ill;
    logic [1:0] e_sb, e_pcs;
    logic [2:0] e_alu;
    {e_pcen, e_iord, e_mrd, e_mwr, e_ir, e_rd, e_m2r, e_rw, e_sa, e_ill} = '0;
    e_sb = 2'b00; e_pcs = 2'b00; e_alu = 3'b010;
    case (st)
      T_RESET:  e_sb = 2'b01;
      T_FETCH:  begin e_mrd = 1'b1; e_sb = 2'b01; e_ir = mr; e_pcen = mr; end
      T_DECODE: begin
        e_sb = 2'b11;
        e_ill = !(o inside {6'b000000, 6'b100011, 6'b101011, 6'b000100,
                            6'b001000, 6'b000010});
      end
      T_MEMADR: begin e_sa = 1'b1; e_sb = 2'b10; end
      T_MEMRD:  begin e_mrd = 1'b1; e_iord = 1'b1; end
      T_MEMWB:  begin e_rw = 1'b1; e_m2r = 1'b1; end
      T_MEMWR:  begin e_mwr = 1'b1; e_iord = 1'b1; end
      T_RTYPEEX: begin
        e_sa = 1'b1;
        case (f)
          6'b100000: e_alu = 3'b010;
          6'b100010: e_alu = 3'b110;
          6'b100100: e_alu = 3'b000;
          6'b100101: e_alu = 3'b001;
          6'b101010: e_alu = 3'b111;
          default:   e_ill = 1'b1;
        endcase
      end
      T_RTYPEWB: begin e_rw = 1'b1; e_rd = 1'b1; end
      T_BEQEX:  begin e_sa = 1'b1; e_alu = 3'b110; e_pcs = 2'b01; e_pcen = z; end
      T_ADDIEX: begin e_sa = 1'b1; e_sb = 2'b10; end
      T_ADDIWB: e_rw = 1'b1;
      T_JEX:    begin e_pcen = 1'b1; e_pcs = 2'b10; end
      default:  e_sb = 2'b01;
    endcase
    return {e_pcen, e_iord, e_mrd, e_mwr, e_ir, e_rd, e_m2r, e_rw, e_sa,
            e_sb, e_pcs, e_alu, e_ill};
  endfunction

  task automatic compare();
    logic [16:0] e;
    string t;
    e = sb_q.pop_front();
    t = tag_q.pop_front();
    n_vec++;
    assert (obs === e) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", t, obs, e);
    end
  endtask

  task automatic check_now(input tb_st_e st, input string tag);
    sb_q.push_back(exp_vec(st, mem_ready, zero, op, funct));
    tag_q.push_back(tag);
    #1;
    compare();
  endtask

  task automatic cyc(input tb_st_e st, input logic mr, input logic z,
                     input logic [5:0] o, input logic [5:0] f, input string tag);
    @(posedge clk);
    #1;
    mem_ready = mr; zero = z; op = o; funct = f;
    sb_q.push_back(exp_vec(st, mr, z, o, f));
    tag_q.push_back(tag);
    @(negedge clk);
    compare();
  endtask

  localparam logic [5:0] RT = 6'b000000, LW = 6'b100011, SW = 6'b101011;
  localparam logic [5:0] BQ = 6'b000100, AI = 6'b001000, JJ = 6'b000010;

  initial begin
    reset_n = 1'b0; mem_ready = 1'b1; zero = 1'b0; op = LW; funct = 6'd0;
    #2 check_now(T_RESET, "reset_hold");
    @(negedge clk);
    reset_n = 1'b1;
    check_now(T_FETCH, "post_reset_fetch");

    cyc(T_DECODE, 1, 0, LW, 0, "lw_decode");
    cyc(T_MEMADR, 1, 0, LW, 0, "lw_memadr");
    cyc(T_MEMRD,  1, 0, LW, 0, "lw_memrd");
    cyc(T_MEMWB,  1, 0, LW, 0, "lw_memwb");
    cyc(T_FETCH,  1, 0, RT, 0, "lw_back_fetch");

    cyc(T_DECODE,  1, 0, RT, 6'b100010, "rsub_decode");
    cyc(T_RTYPEEX, 1, 0, RT, 6'b100010, "rsub_ex");
    cyc(T_RTYPEWB, 1, 0, RT, 6'b100010, "rsub_wb");
    cyc(T_FETCH,   1, 0, RT, 0, "rsub_fetch");
    cyc(T_DECODE,  1, 0, RT, 6'b101010, "rslt_decode");
    cyc(T_RTYPEEX, 1, 0, RT, 6'b101010, "rslt_ex");
    cyc(T_RTYPEWB, 1, 0, RT, 6'b101010, "rslt_wb");
    cyc(T_FETCH,   1, 0, BQ, 0, "rslt_fetch");

    cyc(T_DECODE, 1, 0, BQ, 0, "beq1_decode");
    cyc(T_BEQEX,  1, 1, BQ, 0, "beq_taken");
    cyc(T_FETCH,  1, 0, BQ, 0, "beq1_fetch");
    cyc(T_DECODE, 1, 0, BQ, 0, "beq0_decode");
    cyc(T_BEQEX,  1, 0, BQ, 0, "beq_not_taken");
    cyc(T_FETCH,  0, 0, SW, 0, "fetch_stall1");
    cyc(T_FETCH,  0, 0, SW, 0, "fetch_stall2");
    cyc(T_FETCH,  0, 0, SW, 0, "fetch_stall3");
    cyc(T_FETCH,  1, 0, SW, 0, "fetch_ready");

    cyc(T_DECODE, 1, 0, SW, 0, "sw_decode");
    cyc(T_MEMADR, 1, 0, SW, 0, "sw_memadr");
    cyc(T_MEMWR,  0, 0, SW, 0, "sw_wait1");
    cyc(T_MEMWR,  0, 0, SW, 0, "sw_wait2");
    cyc(T_MEMWR,  0, 0, SW, 0, "sw_wait3");
    cyc(T_MEMWR,  1, 0, SW, 0, "sw_done");
    cyc(T_FETCH,  1, 0, AI, 0, "sw_fetch");

    cyc(T_DECODE, 1, 0, AI, 0, "addi_decode");
    cyc(T_ADDIEX, 1, 0, AI, 0, "addi_ex");
    cyc(T_ADDIWB, 1, 0, AI, 0, "addi_wb");
    cyc(T_FETCH,  1, 0, JJ, 0, "addi_fetch");
    cyc(T_DECODE, 1, 0, JJ, 0, "j_decode");
    cyc(T_JEX,    1, 0, JJ, 0, "j_ex");
    cyc(T_FETCH,  1, 0, 6'b111111, 0, "j_fetch");

    cyc(T_DECODE,  1, 0, 6'b111111, 0, "illegal_op_decode");
    cyc(T_FETCH,   1, 0, RT, 0, "illegal_op_fetch");
    cyc(T_DECODE,  1, 0, RT, 6'b000111, "badfn_decode");
    cyc(T_RTYPEEX, 1, 0, RT, 6'b000111, "badfn_ex");
    cyc(T_FETCH,   1, 0, LW, 0, "badfn_fetch");

    cyc(T_DECODE, 1, 0, LW, 0, "rst_lw_decode");
    cyc(T_MEMADR, 1, 0, LW, 0, "rst_lw_memadr");
    cyc(T_MEMRD,  0, 0, LW, 0, "rst_lw_memrd");
    #1 reset_n = 1'b0;
    check_now(T_RESET, "async_reset_memrd");
    @(posedge clk);
    #1 check_now(T_RESET, "reset_held_edge");
    @(negedge clk);
    reset_n = 1'b1; mem_ready = 1'b1;
    check_now(T_FETCH, "post_reset2_fetch");
    cyc(T_DECODE, 1, 0, LW, 0, "post_reset2_decode");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mc_controller.md
Name: mc_controller

Overview:
- Multicycle main controller that sits directly upstream of the ALU.
- Decodes the instruction register opcode/funct, sequences a Moore FSM over Fetch/Decode/Execute/Memory/Writeback, and drives the datapath enables, mux selects and the 3-bit alucontrol consumed by the ALU.
- Takes the ALU zero flag back to resolve branches.
- Adds a memory-ready wait handshake so slow instruction/data memory stalls the FSM.

Parameters:
- OPW, 6, opcode field width
- FNW, 6, funct field width

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset_n  input  1  asynchronous, active-low reset
- op  input  OPW  instruction opcode from instruction register
- funct  input  FNW  R-type funct field
- zero  input  1  ALU zero flag (valid in BEQEX)
- mem_ready  input  1  memory completes current access this cycle
- pcen  output  1  PC load enable (= pcwrite | (branch & zero))
- iord  output  1  memory address select: 0 = PC, 1 = ALUOut
- memread  output  1  memory read request
- memwrite  output  1  memory write request
- irwrite  output  1  instruction register load
- regdst  output  1  destination register: 0 = rt, 1 = rd
- memtoreg  output  1  writeback source: 0 = ALUOut, 1 = data register
- regwrite  output  1  register file write
- alusrca  output  1  ALU A: 0 = PC, 1 = register A
- alusrcb  output  2  ALU B: 00 = regB, 01 = constant 1, 10 = sign-ext imm, 11 = imm<<1
- pcsrc  output  2  next PC: 00 = ALU result, 01 = ALUOut, 10 = jump target
- alucontrol  output  3  ALU operation
- illegal_op  output  1  one-cycle pulse on undefined opcode/funct

Behaviour:
- Reset is asynchronous and active-low: reset_n=0 immediately forces state to FETCH.
- While reset_n=0, pcen, memread, memwrite, irwrite, regwrite and illegal_op are 0. All other outputs take their FETCH values.
- Outputs are Moore, combinational from state only. Exceptions: pcen also uses zero; alucontrol in RTYPEEX uses funct.
- alucontrol encoding: 010 add, 110 sub, 000 and, 001 or, 111 slt.
- R-type funct decode: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt. Any other funct gives alucontrol 010 and marks the instruction illegal.
- Opcodes: 000000 RTYPE, 100011 LW, 101011 SW, 000100 BEQ, 001000 ADDI, 000010 J. Any other opcode is illegal.
- FETCH: memread=1, iord=0, alusrca=0, alusrcb=01, alucontrol=add, pcsrc=00.
  - irwrite and pcwrite are asserted only when mem_ready=1.
  - Go to DECODE when mem_ready=1, else stay in FETCH.
- DECODE: alusrca=0, alusrcb=11, alucontrol=add (branch target into ALUOut). Next state by opcode:
  - LW/SW -> MEMADR
  - RTYPE -> RTYPEEX
  - BEQ -> BEQEX
  - ADDI -> ADDIEX
  - J -> JEX
  - illegal -> FETCH, with illegal_op=1 for this cycle.
- MEMADR: alusrca=1, alusrcb=10, add. Go to MEMRD if LW, else MEMWR.
- MEMRD: memread=1, iord=1. Wait for mem_ready, then go to MEMWB.
- MEMWB: regwrite=1, regdst=0, memtoreg=1. Go to FETCH.
- MEMWR: memwrite=1, iord=1. Hold until mem_ready, then go to FETCH.
- RTYPEEX: alusrca=1, alusrcb=00, alucontrol from funct.
  - Illegal funct: pulse illegal_op, go to FETCH without writeback.
  - Otherwise go to RTYPEWB.
- RTYPEWB: regwrite=1, regdst=1, memtoreg=0. Go to FETCH.
- BEQEX: alusrca=1, alusrcb=00, sub, branch=1, pcsrc=01. Go to FETCH.
- ADDIEX: alusrca=1, alusrcb=10, add. Go to ADDIWB.
- ADDIWB: regwrite=1, regdst=0, memtoreg=0. Go to FETCH.
- JEX: pcwrite=1, pcsrc=10. Go to FETCH.
- Cycle counts with mem_ready tied to 1:
  - LW = 5
  - SW, RTYPE, ADDI = 4
  - BEQ, J = 3
  - Each cycle with mem_ready=0 in FETCH/MEMRD/MEMWR adds one cycle.
- memwrite stays asserted through every wait cycle of MEMWR. No other write enable is asserted during a wait.
- op/funct are sampled in DECODE/RTYPEEX only and are don't-care elsewhere.
- State encoding: 4-bit enum. Unused encodings fall to FETCH.

Decomposition:
- Shared package (cpu_pkg) holds:
  - the state enum typedef
  - opcode and funct localparams
  - alucontrol localparams (ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT)
  - alusrcb/pcsrc select constants.
- One sub-module, aludec: combinational funct/aluop -> alucontrol plus an illegal flag.
- The FSM and output decode stay in mc_controller.

Test Plan:
- reset_n=0 mid-MEMRD -> state FETCH asynchronously; all write enables 0 during reset; first post-reset cycle shows memread=1, iord=0.
- LW (op=100011), mem_ready=1 -> states FETCH, DECODE, MEMADR, MEMRD, MEMWB; regwrite=1 & memtoreg=1 only in cycle 5; back to FETCH in cycle 6.
- RTYPE sub (funct=100010) -> alucontrol=110 in RTYPEEX; RTYPEWB has regwrite=1, regdst=1.
- BEQ with zero=1 -> pcen=1, pcsrc=01 in BEQEX; with zero=0 -> pcen=0; both return to FETCH.
- FETCH with mem_ready low 3 cycles -> irwrite=0, pcen=0 for 3 cycles, then a single irwrite/pcen pulse; same stall check on MEMWR keeps memwrite=1 for 4 cycles.
- op=111111, then RTYPE with funct=000111 -> illegal_op one-cycle pulse each (in DECODE / RTYPEEX), no regwrite, next state FETCH.
